// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types for the out-of-order core.
//   ReorderBufferTagWidth : width of a ROB tag
//   XLEN                  : integer datapath width
//   fu_complete_t         : completion record produced by an FU shim and
//                           broadcast on the CDB
package riscv_pkg;

  localparam int ReorderBufferTagWidth = 5;
  localparam int XLEN                  = 32;

  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [XLEN-1:0]                  value;
    logic                             exception;
    logic [4:0]                       exc_cause;
    logic [4:0]                       fp_flags;
  } fu_complete_t;

endpackage

// File: rtl/fu_cdb_adapter.sv
// fu_cdb_adapter -- buffers single-cycle FU completions in a small FIFO and
// offers the oldest live entry to the CDB arbiter with a req/grant handshake.
// Entries squashed by a full or partial flush are discarded; killed entries
// retire one per cycle without requesting the bus.
//
// Optional feature (macro FU_CDB_ADAPTER_BYPASS_EN): when the FIFO is empty an
// unflushed incoming completion is offered to the arbiter in the same cycle and
// is only written into the FIFO if it is not granted.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   STALL_MARGIN free entries kept for in-flight ops (1..DEPTH-1)
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_fu_complete    completion from the FU shim (valid is a 1-cycle pulse)
//   o_stall          stop issuing to the FU
//   o_cdb_req        head entry is live and requesting the CDB
//   o_cdb_data       head entry (.valid mirrors o_cdb_req), '0 when empty
//   i_cdb_grant      arbiter accepts o_cdb_data this cycle
//   i_flush          full flush
//   i_flush_en       partial flush, squashes tags younger than i_flush_tag
//   i_flush_tag      partial flush boundary tag
//   i_rob_head_tag   ROB head tag, reference point for age comparison
//   o_count          occupied entries (live plus killed)
//   o_overflow       sticky: a completion was dropped because the FIFO was full
module fu_cdb_adapter #(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  riscv_pkg::fu_complete_t                      i_fu_complete,
  output logic                                         o_stall,
  output logic                                         o_cdb_req,
  output riscv_pkg::fu_complete_t                      o_cdb_data,
  input  logic                                         i_cdb_grant,
  input  logic                                         i_flush,
  input  logic                                         i_flush_en,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]  i_flush_tag,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]  i_rob_head_tag,
  output logic [$clog2(DEPTH):0]                       o_count,
  output logic                                         o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = riscv_pkg::ReorderBufferTagWidth;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_MARGIN);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Age relative to the ROB head, computed one bit wider than a tag so the
  // subtraction never loses its wrap information.
  function automatic logic f_younger(input logic [TW-1:0] tag,
                                     input logic [TW-1:0] head,
                                     input logic [TW-1:0] boundary);
    logic [TW:0] d_tag;
    logic [TW:0] d_bnd;
    d_tag = {1'b0, tag} - {1'b0, head};
    d_bnd = {1'b0, boundary} - {1'b0, head};
    return d_tag > d_bnd;
  endfunction

  riscv_pkg::fu_complete_t r_mem [DEPTH];
  logic [DEPTH-1:0]        r_kill;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_stall;
  logic                    r_overflow;

  riscv_pkg::fu_complete_t w_head;
  logic                    w_not_empty;
  logic                    w_full;
  logic                    w_head_live;
  logic                    w_head_killed;
  logic                    w_head_squash;
  logic                    w_in_squash;
  logic                    w_push_req;
  logic                    w_bypass;
  logic                    w_req;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_ovf_set;
  logic [DEPTH-1:0]        w_occ;
  logic [DEPTH-1:0]        w_kill_nxt;
  logic [CW-1:0]           w_count_nxt;
  logic [PW-1:0]           w_wr_nxt;
  logic [PW-1:0]           w_rd_nxt;

  // Head status, flush masks and the push/pop decisions for this cycle.
  always_comb begin
    w_head        = r_mem[r_rd_ptr];
    w_not_empty   = (r_count != {CW{1'b0}});
    w_full        = (r_count == FULL_CNT);
    w_head_killed = w_not_empty & r_kill[r_rd_ptr];
    w_head_live   = w_not_empty & ~r_kill[r_rd_ptr];
    // Flush masking is combinational so a grant in a flush cycle can never
    // be consumed by an entry that is being squashed.
    w_head_squash = i_flush |
                    (i_flush_en & f_younger(w_head.tag, i_rob_head_tag, i_flush_tag));
    w_in_squash   = i_flush |
                    (i_flush_en & f_younger(i_fu_complete.tag, i_rob_head_tag, i_flush_tag));
    w_push_req    = i_fu_complete.valid & ~w_in_squash;
`ifdef FU_CDB_ADAPTER_BYPASS_EN
    w_bypass      = ~w_not_empty & w_push_req;
`else
    w_bypass      = 1'b0;
`endif
    w_req         = (w_head_live & ~w_head_squash) | w_bypass;
    // A killed head retires on its own, one per cycle, without a request.
    w_pop         = (w_head_live & ~w_head_squash & i_cdb_grant) | w_head_killed;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_push        = w_push_req & ~(w_bypass & i_cdb_grant) & (~w_full | w_pop);
    w_ovf_set     = w_push_req & w_full & ~w_pop;
  end

  // Next-state values for pointers, count and kill bits.
  always_comb begin
    w_occ      = {DEPTH{1'b0}};
    w_kill_nxt = r_kill;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the read pointer is
      // below the current count.
      w_occ[i] = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
    end
    if (i_flush) begin
      w_count_nxt = {CW{1'b0}};
      w_wr_nxt    = {PW{1'b0}};
      w_rd_nxt    = {PW{1'b0}};
      w_kill_nxt  = {DEPTH{1'b0}};
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_wr_nxt    = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      w_rd_nxt    = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
        // A freshly written entry always starts live; otherwise a partial
        // flush marks every occupied younger entry.
        w_kill_nxt[i] = (w_push && (r_wr_ptr == PW'(i))) ? 1'b0 :
                        (r_kill[i] | (i_flush_en & w_occ[i] &
                         f_younger(r_mem[i].tag, i_rob_head_tag, i_flush_tag)));
      end
    end
  end

  // Head presentation toward the arbiter.
  always_comb begin
    o_cdb_data = '0;
    if (w_bypass) begin
      o_cdb_data       = i_fu_complete;
      o_cdb_data.valid = 1'b1;
    end else if (w_not_empty) begin
      o_cdb_data       = w_head;
      o_cdb_data.valid = w_req;
    end else begin
      o_cdb_data = '0;
    end
  end

  // Pointer, count, kill-bit and stall state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_kill   <= {DEPTH{1'b0}};
      r_stall  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_kill   <= w_kill_nxt;
      // Registered from the next count so it tracks the count register.
      r_stall  <= (w_count_nxt >= STALL_CNT);
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_fu_complete;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign o_cdb_req  = w_req;
  assign o_stall    = r_stall;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
